// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered, parametrised ALU with a start/busy/done handshake.
//
// Single-cycle operations (add/sub family, logic, shifts, compare) are
// computed combinationally from the inputs and registered on the accepting
// edge, so done follows one cycle later. Unsigned multiply runs as an
// iterative shift-add, one partial product per cycle, and delivers the
// full 2N-bit product on {out_hi, out}.
//
// Ports:
//   clk      rising-edge system clock
//   reset    asynchronous, active-high reset
//   start    operation request, accepted only while busy = 0
//   mode     operation select (CW bits), sampled with start
//   cin      carry/borrow in for ADC/SBB, sampled with start
//   in_a     operand A (N bits), sampled with start
//   in_b     operand B (N bits), sampled with start
//   busy     high while a multiply is in progress
//   done     one-cycle pulse when out/out_hi/flags/illegal are updated
//   out      result (low half of the product for MUL)
//   out_hi   high half of the MUL product, 0 after other result-writing ops
//   flag_z   result == 0 (full product for MUL)
//   flag_c   carry / borrow / shifted-out bit / (out_hi != 0) for MUL
//   flag_n   MSB of the result
//   flag_v   signed overflow for the add/sub family, else 0
//   illegal  1 when the most recently accepted mode was reserved
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] mode,
    input  logic          cin,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  out,
    output logic [N-1:0]  out_hi,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_n,
    output logic          flag_v,
    output logic          illegal
);

    localparam logic [CW-1:0] OP_ADD = CW'(4'h0);
    localparam logic [CW-1:0] OP_ADC = CW'(4'h1);
    localparam logic [CW-1:0] OP_SUB = CW'(4'h2);
    localparam logic [CW-1:0] OP_SBB = CW'(4'h3);
    localparam logic [CW-1:0] OP_INC = CW'(4'h4);
    localparam logic [CW-1:0] OP_DEC = CW'(4'h5);
    localparam logic [CW-1:0] OP_AND = CW'(4'h6);
    localparam logic [CW-1:0] OP_OR  = CW'(4'h7);
    localparam logic [CW-1:0] OP_XOR = CW'(4'h8);
    localparam logic [CW-1:0] OP_NOT = CW'(4'h9);
    localparam logic [CW-1:0] OP_SHL = CW'(4'hA);
    localparam logic [CW-1:0] OP_SHR = CW'(4'hB);
    localparam logic [CW-1:0] OP_CMP = CW'(4'hC);
    localparam logic [CW-1:0] OP_MUL = CW'(4'hD);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam int CNTW = $clog2(N);

    logic [0:0]      state;
    logic [CNTW-1:0] cnt;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  mcand;
    logic [N-1:0]    mplier;
    logic [2*N-1:0]  acc_next;

    logic [N:0]   arith;
    logic [N-1:0] opnd_b;
    logic [N-1:0] res;
    logic         res_c;
    logic         res_v;
    logic         add_op;
    logic         sub_op;
    logic         is_reserved;
    logic         is_cmp;
    logic         is_mul;

    assign busy   = (state == S_MUL);
    assign is_cmp = (mode == OP_CMP);
    assign is_mul = (mode == OP_MUL);

    // Next partial-product accumulation: add the shifted multiplicand when
    // the current LSB of the multiplier is set.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Single-cycle datapath. Add/sub family runs at N+1 bits so bit N is the
    // carry (add) or borrow (sub, since a negative N+1-bit result sets it).
    // INC/DEC reuse the add/sub overflow rule with an implicit operand of 1.
    always_comb begin
        arith       = '0;
        opnd_b      = in_b;
        res         = '0;
        res_c       = 1'b0;
        res_v       = 1'b0;
        add_op      = 1'b0;
        sub_op      = 1'b0;
        is_reserved = 1'b0;
        case (mode)
            OP_ADD: begin
                add_op = 1'b1;
                arith  = {1'b0, in_a} + {1'b0, in_b};
            end
            OP_ADC: begin
                add_op = 1'b1;
                arith  = {1'b0, in_a} + {1'b0, in_b} + {{N{1'b0}}, cin};
            end
            OP_SUB, OP_CMP: begin
                sub_op = 1'b1;
                arith  = {1'b0, in_a} - {1'b0, in_b};
            end
            OP_SBB: begin
                sub_op = 1'b1;
                arith  = {1'b0, in_a} - {1'b0, in_b} - {{N{1'b0}}, cin};
            end
            OP_INC: begin
                add_op = 1'b1;
                opnd_b = {{(N-1){1'b0}}, 1'b1};
                arith  = {1'b0, in_a} + {{N{1'b0}}, 1'b1};
            end
            OP_DEC: begin
                sub_op = 1'b1;
                opnd_b = {{(N-1){1'b0}}, 1'b1};
                arith  = {1'b0, in_a} - {{N{1'b0}}, 1'b1};
            end
            OP_AND: res = in_a & in_b;
            OP_OR:  res = in_a | in_b;
            OP_XOR: res = in_a ^ in_b;
            OP_NOT: res = ~in_a;
            OP_SHL: begin
                res   = {in_a[N-2:0], 1'b0};
                res_c = in_a[N-1];
            end
            OP_SHR: begin
                res   = {1'b0, in_a[N-1:1]};
                res_c = in_a[0];
            end
            OP_MUL: res = '0;
            default: is_reserved = 1'b1;
        endcase
        if (add_op || sub_op) begin
            res   = arith[N-1:0];
            res_c = arith[N];
            if (add_op) begin
                res_v = (in_a[N-1] == opnd_b[N-1]) && (res[N-1] != in_a[N-1]);
            end else begin
                res_v = (in_a[N-1] != opnd_b[N-1]) && (res[N-1] != in_a[N-1]);
            end
        end
    end

    // Control and result registers. In IDLE a start either completes a
    // single-cycle op on this edge or loads the multiplier; in MUL each edge
    // retires one multiplier bit and the last step writes the full product
    // straight from acc_next so done lands N edges after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            done    <= 1'b0;
            out     <= '0;
            out_hi  <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            mcand   <= {{N{1'b0}}, in_a};
                            mplier  <= in_b;
                            acc     <= '0;
                            cnt     <= '0;
                            illegal <= 1'b0;
                            state   <= S_MUL;
                        end else if (is_reserved) begin
                            illegal <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            illegal <= 1'b0;
                            done    <= 1'b1;
                            flag_z  <= (res == '0);
                            flag_c  <= res_c;
                            flag_n  <= res[N-1];
                            flag_v  <= res_v;
                            if (!is_cmp) begin
                                out    <= res;
                                out_hi <= '0;
                            end
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == CNTW'(N-1)) begin
                        out    <= acc_next[N-1:0];
                        out_hi <= acc_next[2*N-1:N];
                        flag_z <= (acc_next == '0);
                        flag_c <= (acc_next[2*N-1:N] != '0);
                        flag_n <= acc_next[N-1];
                        flag_v <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- scoreboard bench for alu_seq (N = 8).
//
// The stimulus side issues operations and pushes the expected response,
// computed with plain integer arithmetic, into a queue. A monitor process
// pops and compares whenever done is seen, including the edge at which
// done was expected.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int N  = 8;
    localparam int CW = 4;
    localparam int M  = 1 << N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] mode;
    logic          cin;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          busy;
    logic          done;
    logic [N-1:0]  out;
    logic [N-1:0]  out_hi;
    logic          flag_z;
    logic          flag_c;
    logic          flag_n;
    logic          flag_v;
    logic          illegal;

    typedef struct {
        int exp_edge;
        int md;
        int out;
        int hi;
        int z;
        int c;
        int n;
        int v;
        int ill;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    int m_out, m_hi, m_z, m_c, m_n, m_v, m_ill;

    alu_seq #(.N(N), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .cin     (cin),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .out_hi  (out_hi),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .flag_n  (flag_n),
        .flag_v  (flag_v),
        .illegal (illegal)
    );

    // Free-running clock and an edge counter used to time done pulses.
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            edges++;
        end
    end

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    task automatic modelReset();
        m_out = 0; m_hi = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_ill = 0;
    endtask

    // Reference behaviour from the operation definitions: unsigned results
    // by modular arithmetic, carry/borrow by magnitude comparison, overflow
    // by checking the true signed result against the N-bit signed range.
    task automatic modelOp(input int md, input int a, input int b, input int ci);
        int bb, cc, r, sr, res, c, v, p;
        bb = b; cc = 0; r = 0; sr = 0; res = 0; c = 0; v = 0; p = 0;
        if (md >= 14) begin
            m_ill = 1;
        end else if (md == 13) begin
            p     = a * b;
            m_out = p % M;
            m_hi  = p / M;
            m_z   = (p == 0);
            m_c   = (m_hi != 0);
            m_n   = (m_out >= M / 2);
            m_v   = 0;
            m_ill = 0;
        end else begin
            case (md)
                0, 1, 4: begin
                    if (md == 4) bb = 1;
                    if (md == 1) cc = ci;
                    r   = a + bb + cc;
                    sr  = sx(a) + sx(bb) + cc;
                    res = r % M;
                    c   = (r >= M);
                    v   = (sr > M / 2 - 1) || (sr < -(M / 2));
                end
                2, 3, 5, 12: begin
                    if (md == 5) bb = 1;
                    if (md == 3) cc = ci;
                    r   = a - bb - cc;
                    sr  = sx(a) - sx(bb) - cc;
                    res = (r + M) % M;
                    c   = (a < bb + cc);
                    v   = (sr > M / 2 - 1) || (sr < -(M / 2));
                end
                6:  res = a & b;
                7:  res = a | b;
                8:  res = a ^ b;
                9:  res = (~a) & (M - 1);
                10: begin res = (a * 2) % M; c = (a >= M / 2); end
                11: begin res = a / 2;       c = a % 2;         end
                default: res = 0;
            endcase
            m_z   = (res == 0);
            m_c   = c;
            m_n   = (res >= M / 2);
            m_v   = v;
            m_ill = 0;
            if (md != 12) begin
                m_out = res;
                m_hi  = 0;
            end
        end
    endtask

    // Present one operation for the next edge and record its expected
    // response. Back-to-back calls keep start high across cycles.
    task automatic applyStimulus(input int md, input int a, input int b, input int ci);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        mode  = CW'(md);
        in_a  = N'(a);
        in_b  = N'(b);
        cin   = ci[0];
        modelOp(md, a, b, ci);
        e.exp_edge = edges + 1 + ((md == 13) ? N : 0);
        e.md  = md;
        e.out = m_out; e.hi = m_hi;
        e.z   = m_z;   e.c  = m_c; e.n = m_n; e.v = m_v;
        e.ill = m_ill;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        start = 1'b0;
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle_timeout", (n >= 100) ? 1 : 0, 0);
    endtask

    // Monitor: compare every done pulse with the oldest expectation, and
    // flag an expectation whose done edge passed without a pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (done) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput($sformatf("done_edge_m%0d", e.md), edges, e.exp_edge);
                        checkOutput($sformatf("out_m%0d", e.md), out, e.out);
                        checkOutput($sformatf("out_hi_m%0d", e.md), out_hi, e.hi);
                        checkOutput($sformatf("flag_z_m%0d", e.md), flag_z, e.z);
                        checkOutput($sformatf("flag_c_m%0d", e.md), flag_c, e.c);
                        checkOutput($sformatf("flag_n_m%0d", e.md), flag_n, e.n);
                        checkOutput($sformatf("flag_v_m%0d", e.md), flag_v, e.v);
                        checkOutput($sformatf("illegal_m%0d", e.md), illegal, e.ill);
                        checkOutput($sformatf("busy_at_done_m%0d", e.md), busy, 0);
                    end
                end else if (sb.size() != 0 && edges > sb[0].exp_edge) begin
                    e = sb.pop_front();
                    checkOutput($sformatf("done_missing_m%0d", e.md), done, 1);
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_out"}, out, 0);
        checkOutput({tag, "_out_hi"}, out_hi, 0);
        checkOutput({tag, "_flags"}, {flag_z, flag_c, flag_n, flag_v}, 0);
        checkOutput({tag, "_illegal"}, illegal, 0);
    endtask

    initial begin
        int busy_cnt, n, md;
        reset = 1'b1;
        start = 1'b0;
        mode  = '0;
        cin   = 1'b0;
        in_a  = '0;
        in_b  = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        // Warm up with a result so the mid-multiply reset has state to clear.
        applyStimulus(0, 8'h33, 8'h44, 0);
        idle();
        waitIdle();

        $display("[TB] reset during multiply");
        applyStimulus(13, 8'h37, 8'h5A, 0);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("busy_mid_mul", busy, 1);
        reset = 1'b1;
        sb.delete();
        modelReset();
        #1;
        checkAllZero("async_reset");
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            checkOutput("no_done_after_reset", done, 0);
        end

        $display("[TB] directed arithmetic");
        applyStimulus(0, 8'h01, 8'h01, 0);
        applyStimulus(0, 8'hFF, 8'h01, 0);
        applyStimulus(1, 8'h7F, 8'h00, 1);
        applyStimulus(2, 8'h10, 8'h20, 0);
        applyStimulus(12, 8'h05, 8'h05, 0);
        idle();
        waitIdle();

        $display("[TB] multiply with ignored start");
        applyStimulus(13, 8'hFF, 8'hFF, 0);
        busy_cnt = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            start = busy && (busy_cnt == 3);
            mode  = 4'h0;
            in_a  = N'($urandom);
            in_b  = N'($urandom);
        end while (busy && n < 40);
        start = 1'b0;
        checkOutput("mul_busy_cycles", busy_cnt, N);
        waitIdle();

        $display("[TB] shifts and back-to-back logic");
        applyStimulus(10, 8'h81, 8'h00, 0);
        applyStimulus(11, 8'h01, 8'h00, 0);
        applyStimulus(6, 8'hF0, 8'h3C, 0);
        applyStimulus(7, 8'hF0, 8'h3C, 0);
        applyStimulus(8, 8'hF0, 8'h3C, 0);
        idle();
        waitIdle();

        $display("[TB] reserved mode");
        applyStimulus(0, 8'h40, 8'h02, 0);
        applyStimulus(14, 8'h12, 8'h34, 1);
        idle();
        waitIdle();
        checkOutput("illegal_held", illegal, 1);
        applyStimulus(4, 8'h42, 8'h00, 0);
        idle();
        waitIdle();

        $display("[TB] random operations");
        for (int i = 0; i < 80; i++) begin
            md = $urandom_range(0, 15);
            applyStimulus(md, $urandom_range(0, M - 1), $urandom_range(0, M - 1),
                          $urandom_range(0, 1));
            if (md == 13 || $urandom_range(0, 3) == 0) begin
                idle();
                waitIdle();
            end
        end
        idle();
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's combinational 8-bit ALU.
- Adds logic, shift, compare and an iterative multiply, plus a registered flag set (Z, C, N, V).
- Uses a start/busy/done handshake, so the control sequencer can issue multi-cycle operations.
- Sits between the register file/bus and the flags register in the datapath.

Parameters:
- N, 8, operand/result width in bits (N >= 4).
- CW, 4, width of mode input; fixed encoding below requires CW = 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  operation request; accepted only when busy = 0.
- mode  input  CW  operation select, sampled with start.
- cin  input  1  carry/borrow in, sampled with start.
- in_a  input  N  operand A, sampled with start.
- in_b  input  N  operand B, sampled with start.
- busy  output  1  high while an accepted operation is in progress.
- done  output  1  one-cycle pulse when out/out_hi/flags are updated.
- out  output  N  result (low half for MUL).
- out_hi  output  N  high half of MUL product; 0 for all other ops.
- flag_z  output  1  registered: out == 0 (MUL: full 2N product == 0).
- flag_c  output  1  registered carry / borrow / shifted-out bit.
- flag_n  output  1  registered MSB of out.
- flag_v  output  1  registered signed overflow (ADD/ADC/SUB/SBB/INC/DEC/CMP only, else 0).
- illegal  output  1  registered; 1 if the last accepted mode was reserved.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy, done, out, out_hi, all flags and illegal = 0. Any operation in flight is abandoned; no done pulse.
- Mode encoding:
  - 0 ADD: A+B
  - 1 ADC: A+B+cin
  - 2 SUB: A-B
  - 3 SBB: A-B-cin
  - 4 INC: A+1
  - 5 DEC: A-1
  - 6 AND
  - 7 OR
  - 8 XOR
  - 9 NOT: ~A
  - A SHL: A<<1, C = A[N-1]
  - B SHR: logical A>>1, C = A[0]
  - C CMP: as SUB but out unchanged, flags updated
  - D MUL: unsigned AxB
  - E, F reserved
- Arithmetic: computed at N+1 bits. C = bit N of the sum for add-type ops. For subtract-type ops (SUB, SBB, DEC, CMP), C = borrow, i.e. 1 when the unsigned minuend is less than the subtrahend (+cin for SBB).
- V (signed overflow): operand signs equal and result sign differs (add-type); operand signs differ and result sign differs from A (subtract-type).
- Logic ops: C = 0, V = 0.
- State machine states:
  - IDLE: busy = 0.
    - start=1 with a single-cycle mode: capture operands, compute, register out/flags on the same edge. Next cycle: done = 1, busy stays 0. Latency 1.
    - start=1 with MUL: capture A and B; clear accumulator and counter; go to MUL; busy = 1 from the next cycle.
    - start=1 with a reserved mode: out, out_hi and flags unchanged; illegal = 1; done pulses next cycle.
    - Any legal op clears illegal.
  - MUL: one shift-add step per cycle, LSB-first over B, counter 0..N-1. After N steps, register {out_hi, out} = product; Z updated; C = (out_hi != 0); N = out[N-1]; V = 0. Return to IDLE with done = 1 that cycle and busy = 0. Latency from start edge to done = N+1 cycles.
- out_hi is cleared to 0 by every legal non-MUL op except CMP, which leaves out and out_hi unchanged.
- start while busy = 1: ignored; no effect on the operation in progress.
- start held high continuously in IDLE: a new op is accepted every cycle for single-cycle modes. done is asserted on each following cycle, back-to-back.
- Outputs are stable between done pulses. Operand inputs may change freely after acceptance.

Test Plan:
- N=8, reset asserted mid-MUL (cycle 4) -> busy=0, out=0, out_hi=0, all flags 0, no done pulse; next start ADD 1+1 -> out=0x02 after 1 cycle.
- ADD 0xFF+0x01 -> out=0x00, Z=1, C=1, V=0, done 1 cycle after start. ADC 0x7F+0x00 with cin=1 -> out=0x80, N=1, V=1, C=0.
- SUB 0x10-0x20 -> out=0xF0, C=1 (borrow), N=1. CMP 0x05 vs 0x05 -> Z=1, C=0, out keeps the previous value.
- MUL 0xFF x 0xFF -> busy for 8 cycles, done 9 cycles after start, out_hi=0xFE, out=0x01, C=1. A start pulse during busy is ignored and the result is unchanged.
- SHL 0x81 -> out=0x02, C=1. SHR 0x01 -> out=0x00, C=1, Z=1. Back-to-back AND/OR/XOR with start held high -> three consecutive done pulses with the correct results.
- Mode 0xE after ADD result 0x42 -> illegal=1, out=0x42, flags unchanged, done pulses. Next INC 0x42 -> out=0x43, illegal=0.
